// File: rtl/fm_op_out.sv
// fm_op_out: FM operator output stage (log-sine -> attenuation -> exponent) plus carrier mixer.
// Define FM_WAVESEL_EN to honour in_wave_i (OPL2 waveforms 0-3); otherwise every slot is a full sine.
module fm_op_out #(
  parameter int unsigned ACC_W = 20
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  input  logic [5:0]  in_op_i,
  input  logic [9:0]  in_phase_i,
  input  logic [8:0]  in_env_i,
  input  logic [1:0]  in_wave_i,
  input  logic        in_carrier_i,
  input  logic        in_last_i,
  output logic        out_valid_o,
  output logic [5:0]  out_op_o,
  output logic [12:0] out_val_o,
  output logic [15:0] sample_o,
  output logic        sample_valid_o
);

  localparam longint QOne = 64'sd1 <<< 30;

  // round(-log2(sin((i+0.5)*pi/512))*256) in Q30 integer arithmetic, folded at elaboration.
  function automatic logic [11:0] logsin_f(input int i);
    longint x, s, term, m, f;
    int k;
    x = (longint'(2 * i + 1) * 64'sd3373259426) >>> 10;
    s = x;
    term = x;
    for (int n = 1; n <= 12; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * n) * (2 * n + 1));
      s = s + term;
    end
    m = s;
    k = 0;
    for (int j = 0; j < 16; j++) begin
      if (m < QOne) begin
        m = m <<< 1;
        k++;
      end
    end
    f = 0;
    for (int b = 0; b < 20; b++) begin
      m = (m * m) >>> 30;
      f = f <<< 1;
      if (m >= (QOne <<< 1)) begin
        m = m >>> 1;
        f = f + 1;
      end
    end
    return 12'(((longint'(k) <<< 20) - f + 2048) >>> 12);
  endfunction

  function automatic longint isqrt_f(input longint v);
    longint r, t;
    r = 0;
    for (int b = 30; b >= 0; b--) begin
      t = r | (64'sd1 <<< b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  // round((2^(i/256) - 1) * 1024): product of 2^(2^b/256) roots for each set bit of i.
  function automatic logic [9:0] exp_f(input int i);
    longint p, root;
    p = QOne;
    root = QOne <<< 1;
    for (int j = 0; j < 8; j++) begin
      root = isqrt_f(root <<< 30);
      if (i[7-j]) p = (p * root) >>> 30;
    end
    return 10'(((p - QOne) + (64'sd1 <<< 19)) >>> 20);
  endfunction

  logic [11:0] logsin_rom [256];
  logic [9:0]  exp_rom    [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign logsin_rom[g] = logsin_f(g);
    assign exp_rom[g]    = exp_f(g);
  end

  // Stage 1: log-sine lookup and waveform shaping.
  logic [7:0]  idx;
  logic [11:0] ls_d;
  logic        sign_d, mute_d;

  assign idx  = in_phase_i[8] ? ~in_phase_i[7:0] : in_phase_i[7:0];
  assign ls_d = logsin_rom[idx];

`ifdef FM_WAVESEL_EN
  always_comb begin
    sign_d = in_phase_i[9];
    mute_d = 1'b0;
    unique case (in_wave_i)
      2'd0: ;
      2'd1: mute_d = in_phase_i[9];
      2'd2: sign_d = 1'b0;
      2'd3: begin
        mute_d = in_phase_i[8];
        sign_d = 1'b0;
      end
      default: ;
    endcase
  end
`else
  logic unused_wave;
  assign unused_wave = ^in_wave_i;
  assign sign_d      = in_phase_i[9];
  assign mute_d      = 1'b0;
`endif

  logic        s1_valid_q, s1_sign_q, s1_mute_q, s1_carrier_q, s1_last_q;
  logic [5:0]  s1_op_q;
  logic [11:0] s1_ls_q;
  logic [8:0]  s1_env_q;

  // Stage 2: attenuation and exponent lookup.
  logic [12:0] total;
  logic [7:0]  exp_idx;
  logic [10:0] mant_d;

  assign total   = {1'b0, s1_ls_q} + {1'b0, s1_env_q, 3'b000};
  assign exp_idx = ~total[7:0];
  assign mant_d  = 11'd1024 + {1'b0, exp_rom[exp_idx]};

  logic        s2_valid_q, s2_sign_q, s2_mute_q, s2_carrier_q, s2_last_q;
  logic [5:0]  s2_op_q;
  logic [10:0] s2_mant_q;
  logic [4:0]  s2_shift_q;

  // Stage 3: magnitude, sign and carrier accumulation.
  logic [11:0]             shifted, mag;
  logic [12:0]             val_d;
  logic [ACC_W-1:0]        contrib, acc_sum;
  logic [ACC_W-16:0]       acc_top;
  logic [15:0]             sat;

  assign shifted = {s2_mant_q, 1'b0} >> s2_shift_q;
  assign mag     = (s2_mute_q || s2_shift_q >= 5'd12) ? 12'd0 : shifted;
  assign val_d   = s2_sign_q ? -{1'b0, mag} : {1'b0, mag};
  assign contrib = s2_carrier_q ? {{(ACC_W-13){val_d[12]}}, val_d} : '0;

  logic [ACC_W-1:0] acc_q;
  logic [12:0]      out_val_q;
  logic [5:0]       out_op_q;
  logic [15:0]      sample_q;
  logic             out_valid_q, sample_valid_q;

  assign acc_sum = acc_q + contrib;
  assign acc_top = acc_sum[ACC_W-1:15];
  // In range when every bit above bit 15 matches the sign bit.
  assign sat = (&acc_top || ~|acc_top) ? acc_sum[15:0]
                                       : (acc_sum[ACC_W-1] ? 16'h8000 : 16'h7fff);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q     <= 1'b0;
      s1_sign_q      <= 1'b0;
      s1_mute_q      <= 1'b0;
      s1_carrier_q   <= 1'b0;
      s1_last_q      <= 1'b0;
      s1_op_q        <= '0;
      s1_ls_q        <= '0;
      s1_env_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_sign_q      <= 1'b0;
      s2_mute_q      <= 1'b0;
      s2_carrier_q   <= 1'b0;
      s2_last_q      <= 1'b0;
      s2_op_q        <= '0;
      s2_mant_q      <= '0;
      s2_shift_q     <= '0;
      out_valid_q    <= 1'b0;
      out_op_q       <= '0;
      out_val_q      <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      acc_q          <= '0;
    end else begin
      s1_valid_q     <= in_valid_i;
      s2_valid_q     <= s1_valid_q;
      out_valid_q    <= s2_valid_q;
      sample_valid_q <= s2_valid_q & s2_last_q;
      if (in_valid_i) begin
        s1_sign_q    <= sign_d;
        s1_mute_q    <= mute_d;
        s1_carrier_q <= in_carrier_i;
        s1_last_q    <= in_last_i;
        s1_op_q      <= in_op_i;
        s1_ls_q      <= ls_d;
        s1_env_q     <= in_env_i;
      end
      if (s1_valid_q) begin
        s2_sign_q    <= s1_sign_q;
        s2_mute_q    <= s1_mute_q;
        s2_carrier_q <= s1_carrier_q;
        s2_last_q    <= s1_last_q;
        s2_op_q      <= s1_op_q;
        s2_mant_q    <= mant_d;
        s2_shift_q   <= total[12:8];
      end
      if (s2_valid_q) begin
        out_op_q  <= s2_op_q;
        out_val_q <= val_d;
        if (s2_last_q) begin
          sample_q <= sat;
          acc_q    <= '0;
        end else begin
          acc_q    <= acc_sum;
        end
      end
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_op_o       = out_op_q;
  assign out_val_o      = out_val_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;

endmodule
